// File: rtl/down_timer.sv
// Loadable down-counting timer with a registered terminal-count borrow pulse.
// Counts a programmed value to zero, then stops (DONE) or reloads and keeps running.
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             hold,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             borrow,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Control interface: load and start are single-cycle strobes sampled on the
    // rising edge; load beats start, start beats hold. hold is a level that only
    // matters while a run is active. There is no back-pressure: every strobe is
    // accepted or ignored in the cycle it is presented.

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] reload_q;
    logic             active;
    logic             at_zero;

    assign active  = (state == S_RUN) || (state == S_PAUSED);
    assign at_zero = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            reload_q <= '0;
            borrow   <= 1'b0;
            state    <= S_IDLE;
        end else if (load) begin
            count    <= load_value;
            reload_q <= load_value;
            borrow   <= 1'b0;
            state    <= S_IDLE;
        end else begin
            borrow <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    // Count is left alone here; the first decrement happens one
                    // cycle after RUN is entered.
                    if (start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN, S_PAUSED: begin
                    if (hold) begin
                        state <= S_PAUSED;
                    end else begin
                        state <= S_RUN;
                        if (!at_zero) begin
                            count <= count - 1'b1;
                        end else begin
                            borrow <= 1'b1;
                            if (auto_reload) begin
                                count <= reload_q;
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = active;
    assign paused    = (state == S_PAUSED);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: each task drives one scenario and compares the
// packed output bundle {count, borrow, busy, paused, done} against hand-computed values.
module tb_down_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         hold;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         borrow;
    logic         busy;
    logic         paused;
    logic         done;
    logic [1:0]   state_dbg;

    int vectors = 0;
    int errors  = 0;

    logic [W+3:0] obs;
    assign obs = {count, borrow, busy, paused, done};

    down_timer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .hold(hold), .auto_reload(auto_reload),
        .count(count), .borrow(borrow), .busy(busy), .paused(paused),
        .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs set after this are seen at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1;
        load_value = v;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 0; load_value = 0; start = 0; hold = 0; auto_reload = 0;
        step();
        step();
        reset = 1'b0;
        vectors++;
        if (obs !== {8'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=%h", obs, {8'd0, 4'b0000});
        end
        vectors++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got=%0d want=0", state_dbg);
        end
    endtask

    task automatic test_one_shot();
        logic [W-1:0] exp_cnt;
        auto_reload = 1'b0;
        do_load(8'd3);
        vectors++;
        if (obs !== {8'd3, 4'b0000}) begin
            errors++;
            $display("FAIL one_shot_loaded got=%h want=%h", obs, {8'd3, 4'b0000});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp_cnt = 8'(4 - k);
            vectors++;
            if (obs !== {exp_cnt, 4'b0100}) begin
                errors++;
                $display("FAIL one_shot_T+%0d got=%h want=%h", k, obs, {exp_cnt, 4'b0100});
            end
            if (k < 4) step();
        end
        step();
        vectors++;
        if (obs !== {8'd0, 4'b1001}) begin
            errors++;
            $display("FAIL one_shot_borrow got=%h want=%h", obs, {8'd0, 4'b1001});
        end
        for (int k = 0; k < 3; k++) begin
            step();
            hold = (k == 1);
            vectors++;
            if (obs !== {8'd0, 4'b0001}) begin
                errors++;
                $display("FAIL one_shot_after_%0d got=%h want=%h", k, obs, {8'd0, 4'b0001});
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_auto_reload();
        logic [W-1:0] exp_cnt;
        logic         exp_b;
        auto_reload = 1'b1;
        do_load(8'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_cnt = 8'(2 - (i % 3));
            exp_b   = (i >= 3) && (i % 3 == 0);
            vectors++;
            if (obs !== {exp_cnt, exp_b, 3'b100}) begin
                errors++;
                $display("FAIL auto_reload_T+%0d got=%h want=%h", i + 1, obs, {exp_cnt, exp_b, 3'b100});
            end
            step();
        end
        auto_reload = 1'b0;
    endtask

    task automatic test_hold();
        do_load(8'd4);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        vectors++;
        if (obs !== {8'd2, 4'b0100}) begin
            errors++;
            $display("FAIL hold_pre got=%h want=%h", obs, {8'd2, 4'b0100});
        end
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 2) hold = 1'b0;
            vectors++;
            if (obs !== {8'd2, 4'b0110}) begin
                errors++;
                $display("FAIL hold_paused_%0d got=%h want=%h", k, obs, {8'd2, 4'b0110});
            end
        end
        step();
        vectors++;
        if (obs !== {8'd1, 4'b0100}) begin
            errors++;
            $display("FAIL hold_release1 got=%h want=%h", obs, {8'd1, 4'b0100});
        end
        step();
        vectors++;
        if (obs !== {8'd0, 4'b0100}) begin
            errors++;
            $display("FAIL hold_release0 got=%h want=%h", obs, {8'd0, 4'b0100});
        end
        step();
        vectors++;
        if (obs !== {8'd0, 4'b1001}) begin
            errors++;
            $display("FAIL hold_borrow got=%h want=%h", obs, {8'd0, 4'b1001});
        end
    endtask

    task automatic test_load_abort();
        do_load(8'd10);
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        vectors++;
        if (obs !== {8'd7, 4'b0100}) begin
            errors++;
            $display("FAIL abort_pre got=%h want=%h", obs, {8'd7, 4'b0100});
        end
        load = 1'b1; load_value = 8'd9; start = 1'b1;
        step();
        load = 1'b0; start = 1'b1;
        vectors++;
        if (obs !== {8'd9, 4'b0000} || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL abort_load got=%h/%0d want=%h/0", obs, state_dbg, {8'd9, 4'b0000});
        end
        step();
        start = 1'b0;
        vectors++;
        if (obs !== {8'd9, 4'b0100}) begin
            errors++;
            $display("FAIL abort_restart got=%h want=%h", obs, {8'd9, 4'b0100});
        end
        step();
        vectors++;
        if (obs !== {8'd8, 4'b0100}) begin
            errors++;
            $display("FAIL abort_dec got=%h want=%h", obs, {8'd8, 4'b0100});
        end
    endtask

    task automatic test_reset_mid_run();
        do_load(8'd5);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (obs !== {8'd0, 4'b0000}) begin
            errors++;
            $display("FAIL midrun_reset got=%h want=%h", obs, {8'd0, 4'b0000});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if (obs !== {8'd0, 4'b0100}) begin
            errors++;
            $display("FAIL midrun_restart got=%h want=%h", obs, {8'd0, 4'b0100});
        end
        step();
        vectors++;
        if (obs !== {8'd0, 4'b1001}) begin
            errors++;
            $display("FAIL midrun_borrow got=%h want=%h", obs, {8'd0, 4'b1001});
        end
    endtask

    task automatic test_boundary();
        logic [W-1:0] exp_cnt;
        auto_reload = 1'b0;
        do_load(8'hFF);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            exp_cnt = 8'(256 - k);
            vectors++;
            if (obs !== {exp_cnt, 4'b0100}) begin
                errors++;
                $display("FAIL boundary_ff_T+%0d got=%h want=%h", k, obs, {exp_cnt, 4'b0100});
            end
            step();
        end
        vectors++;
        if (obs !== {8'd0, 4'b1001}) begin
            errors++;
            $display("FAIL boundary_ff_borrow got=%h want=%h", obs, {8'd0, 4'b1001});
        end
        auto_reload = 1'b1;
        do_load(8'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if (obs !== {8'd0, 4'b0100}) begin
            errors++;
            $display("FAIL boundary_zero_T+1 got=%h want=%h", obs, {8'd0, 4'b0100});
        end
        for (int k = 2; k <= 6; k++) begin
            step();
            vectors++;
            if (obs !== {8'd0, 4'b1100}) begin
                errors++;
                $display("FAIL boundary_zero_T+%0d got=%h want=%h", k, obs, {8'd0, 4'b1100});
            end
        end
        auto_reload = 1'b0;
        step();
        step();
        vectors++;
        if (obs !== {8'd0, 4'b0001}) begin
            errors++;
            $display("FAIL boundary_zero_stop got=%h want=%h", obs, {8'd0, 4'b0001});
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_hold();
        test_load_abort();
        test_reset_mid_run();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
